cfg_chain_loader: RTL and testbench
===================================

Name: cfg_chain_loader

Overview:
- Parametrised configuration loader for the custom FPGA fabric; the successor to the fixed single-chain bitstream shift-in.
- Streams a bitstream into NUM_CHAINS parallel configuration shift chains of CHAIN_LEN bits each, one bit per chain per beat, and verifies a trailing XOR checksum beat.
- Supports non-destructive readback: chains are rotated back to their original contents.
- Sits between the top-level pin wrapper (ui_in/uio_in decode) and the fabric's configuration chains.

Parameters:
- NUM_CHAINS, 4, number of parallel config chains; also the beat width.
- CHAIN_LEN, 64, bits per chain; beats per load or readback; must be >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; low freezes all state
- start  in  1  single-cycle request to begin an operation
- mode  in  1  0 = load, 1 = readback; sampled with start
- in_valid  in  1  bitstream beat valid
- in_data  in  NUM_CHAINS  bitstream beat; bit i goes to chain i
- in_ready  out  1  loader accepts a beat this cycle
- out_valid  out  1  readback beat valid
- out_data  out  NUM_CHAINS  readback beat
- out_ready  in  1  consumer accepts a readback beat
- chain_en  out  1  shift strobe to all chains
- chain_din  out  NUM_CHAINS  serial input to each chain
- chain_dout  in  NUM_CHAINS  serial output of each chain (last stage)
- busy  out  1  high in LOAD, CHECK and READBACK
- done  out  1  one-cycle pulse when an operation ends
- error  out  1  sticky checksum-mismatch flag
- cfg_valid  out  1  fabric holds a verified configuration

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, beat counter 0, XOR accumulator 0. All outputs 0: in_ready, out_valid, out_data, chain_en, chain_din, busy, done, error, cfg_valid.
- ena low: no state, counter or accumulator change. in_ready, out_valid and chain_en forced 0. done cannot pulse. Operation resumes exactly where it stopped when ena returns.
- IDLE:
  - start & ~mode -> LOAD. Same edge: cfg_valid <= 0, error <= 0, counter <= 0, accumulator <= 0.
  - start & mode -> READBACK, counter <= 0. cfg_valid and error are unchanged.
- LOAD:
  - in_ready = 1.
  - On an accepted beat (in_valid & in_ready): chain_en = 1 in that same cycle, combinationally. chain_din = in_data. accumulator ^= in_data. counter++.
  - When the CHAIN_LEN-th beat is accepted -> CHECK.
- CHECK:
  - in_ready = 1 and chain_en = 0; the checksum beat is not shifted into the chains.
  - On accept: if in_data == accumulator, cfg_valid <= 1. Otherwise error <= 1 and cfg_valid stays 0.
  - Then done pulses for one cycle and the block -> IDLE.
- READBACK:
  - out_valid = 1, out_data = chain_dout.
  - On out_valid & out_ready: chain_en = 1, chain_din = chain_dout (rotate), counter++.
  - After CHAIN_LEN handshakes, chains hold their original contents; done pulses and the block -> IDLE.
  - cfg_valid is untouched.
- start while busy: ignored; no restart.
- Handshake stalls: in_valid or out_ready low for any number of cycles inserts no shifts and leaves all state unchanged.
- Counter: width $clog2(CHAIN_LEN+1). Compare against CHAIN_LEN-1 on the accepting beat; no wrap past CHAIN_LEN.
- done: registered; it asserts in the cycle after the final handshake, while state is already IDLE.
- Reset during LOAD: immediately IDLE with cfg_valid 0. Chain contents are undefined and become the fabric's problem.

Decomposition:
- Shared package cfg_pkg: state enum (IDLE, LOAD, CHECK, READBACK) and MODE_LOAD/MODE_READBACK constants.
- One natural sub-module, cfg_beat_counter: parametrised up-counter with clear, enable and last-beat flag; reused by the future per-tile loader.
- Datapath and FSM stay in cfg_chain_loader.

Test Plan (NUM_CHAINS=4, CHAIN_LEN=8):
- Load beats 1,2,3,4,5,6,7,8, then checksum 4'h8 -> exactly 8 chain_en pulses, chain_din matches each beat, done one cycle, cfg_valid=1, error=0.
- Same beats with checksum 4'h0 -> error=1, cfg_valid=0, done pulses; the next good load clears error and sets cfg_valid.
- After a good load, readback with out_ready toggling 1,0,1,0,... -> out_data sequence 1..8, 8 chain_en pulses, chain contents unchanged (second readback identical), cfg_valid stays 1.
- During LOAD, drop ena for 5 cycles after beat 3 and pulse start -> no shifts, no state change, start ignored; completion identical to the uninterrupted run.
- Assert rst_n low mid-LOAD after beat 4 -> all outputs 0 asynchronously, state IDLE; a fresh load then succeeds.
- In IDLE, start with in_valid held 0 for 20 cycles -> busy=1, in_ready=1, no chain_en, counter 0.

Source files
------------

// File: rtl/cfg_pkg.sv
// cfg_pkg: shared state encoding and mode constants for the configuration loader.
package cfg_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, READBACK} state_t;
    localparam logic MODE_LOAD     = 1'b0;
    localparam logic MODE_READBACK = 1'b1;
endpackage

// File: rtl/cfg_beat_counter.sv
// cfg_beat_counter: beat up-counter with clear, increment and last-beat flag.
module cfg_beat_counter #(
    parameter int LEN = 64,
    parameter int W   = $clog2(LEN + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         last
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && count != W'(LEN))
            count <= count + 1'b1;
    end
    assign last = count == W'(LEN - 1);
endmodule

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: streams a bitstream into parallel config chains, verifies an
// XOR checksum beat, and supports non-destructive rotating readback.
module cfg_chain_loader
    import cfg_pkg::*;
#(
    parameter int NUM_CHAINS = 4,
    parameter int CHAIN_LEN  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  in_valid,
    input  logic [NUM_CHAINS-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [NUM_CHAINS-1:0] out_data,
    input  logic                  out_ready,
    output logic                  chain_en,
    output logic [NUM_CHAINS-1:0] chain_din,
    input  logic [NUM_CHAINS-1:0] chain_dout,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cfg_valid
);
    localparam int CW = $clog2(CHAIN_LEN + 1);

    state_t                state, state_nx;
    logic [CW-1:0]         count;
    logic                  last;
    logic [NUM_CHAINS-1:0] acc;
    logic                  start_ok, load_hs, chk_hs, rb_hs;

    // Handshakes are built from ena/state directly so no output feeds back into them.
    assign start_ok = ena & start & (state == IDLE);
    assign load_hs  = ena & in_valid & (state == LOAD);
    assign chk_hs   = ena & in_valid & (state == CHECK);
    assign rb_hs    = ena & out_ready & (state == READBACK);

    cfg_beat_counter #(.LEN(CHAIN_LEN), .W(CW)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .inc   (load_hs | rb_hs),
        .count (count),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     state_nx = start_ok ? (mode == MODE_READBACK ? READBACK : LOAD) : IDLE;
            LOAD:     state_nx = (load_hs && last) ? CHECK : LOAD;
            CHECK:    state_nx = chk_hs ? IDLE : CHECK;
            READBACK: state_nx = (rb_hs && last) ? IDLE : READBACK;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = ena & (state == LOAD || state == CHECK);
        out_valid = ena & (state == READBACK);
        out_data  = (state == READBACK) ? chain_dout : '0;
        chain_en  = load_hs | rb_hs;
        chain_din = (state == LOAD) ? in_data : (state == READBACK) ? chain_dout : '0;
        busy      = state != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cfg_valid <= 1'b0;
            error     <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= chk_hs | (rb_hs & last);
            if (start_ok && mode == MODE_LOAD) begin
                acc       <= '0;
                cfg_valid <= 1'b0;
                error     <= 1'b0;
            end
            if (load_hs)
                acc <= acc ^ in_data;
            if (chk_hs) begin
                cfg_valid <= in_data == acc;
                error     <= error | (in_data != acc);
            end
        end
    end
endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader: scoreboard bench with a behavioural model of the fabric chains.
module tb_cfg_chain_loader;
    localparam int NC = 4;
    localparam int CL = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          in_valid = 1'b0;
    logic [NC-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [NC-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          chain_en;
    logic [NC-1:0] chain_din;
    logic [NC-1:0] chain_dout;
    logic          busy, done, error, cfg_valid;

    logic [NC-1:0][CL-1:0] chains = '0;
    logic [NC-1:0]         dinq[$];
    logic [NC-1:0]         rbq[$];
    int                    errs = 0;
    int                    checks = 0;
    int                    en_cnt = 0;

    cfg_chain_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(CL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .chain_en   (chain_en),
        .chain_din  (chain_din),
        .chain_dout (chain_dout),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cfg_valid  (cfg_valid)
    );

    always #5 clk = ~clk;

    // Fabric model: each chain shifts toward its last stage on chain_en.
    always @(posedge clk)
        if (chain_en)
            for (int i = 0; i < NC; i++)
                chains[i] <= {chains[i][CL-2:0], chain_din[i]};

    always_comb
        for (int i = 0; i < NC; i++)
            chain_dout[i] = chains[i][CL-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chain_en)
            en_cnt++;
        if (chain_en && !out_valid) begin
            if (dinq.size() == 0)
                check("din_extra_shift", chain_en, 0);
            else
                check("chain_din", chain_din, dinq.pop_front());
        end
        if (out_valid && out_ready) begin
            if (rbq.size() == 0)
                check("rb_extra_beat", out_valid, 0);
            else
                check("out_data", out_data, rbq.pop_front());
        end
    end

    task automatic do_start(input logic m);
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [NC-1:0] d, input bit shifted);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 50)
            check("in_ready_timeout", in_ready, 1);
        if (shifted)
            dinq.push_back(d);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_beats(input int from, input int to);
        for (int i = from; i <= to; i++)
            send_beat(NC'(i + 1), 1'b1);
    endtask

    task automatic finish_load(input logic [NC-1:0] csum, input bit good, input int e0);
        send_beat(csum, 1'b0);
        check("done_pulse", done, 1);
        check("busy_after", busy, 0);
        check("cfg_valid", cfg_valid, good);
        check("error", error, !good);
        check("load_shifts", en_cnt - e0, CL);
        check("din_q_drained", dinq.size(), 0);
        @(posedge clk); #1;
        check("done_single", done, 0);
    endtask

    task automatic run_load(input logic [NC-1:0] csum, input bit good);
        int e0 = en_cnt;
        do_start(1'b0);
        send_beats(0, CL - 1);
        finish_load(csum, good, e0);
    endtask

    task automatic readback();
        int e0 = en_cnt;
        int hs = 0;
        int n = 0;
        logic [NC-1:0][CL-1:0] snap = chains;
        for (int i = 0; i < CL; i++)
            rbq.push_back(NC'(i + 1));
        do_start(1'b1);
        while (hs < CL && n < 200) begin
            out_ready = (n % 2) == 0;
            if (out_valid && out_ready)
                hs++;
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        check("rb_handshakes", hs, CL);
        check("rb_done", done, 1);
        check("rb_shifts", en_cnt - e0, CL);
        check("rb_q_drained", rbq.size(), 0);
        check("rb_chains_kept", chains, snap);
        check("rb_cfg_valid", cfg_valid, 1);
        @(posedge clk); #1;
        check("rb_done_single", done, 0);
    endtask

    initial begin
        int e0;
        repeat (3) @(posedge clk);
        check("reset_outs", {in_ready, out_valid, out_data, chain_en, chain_din, busy, done, error, cfg_valid}, 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_load(NC'(8), 1'b1);
        run_load(NC'(0), 1'b0);
        run_load(NC'(8), 1'b1);

        readback();
        readback();

        // ena low mid-load with a start pulse: everything freezes
        e0 = en_cnt;
        do_start(1'b0);
        send_beats(0, 2);
        ena = 1'b0;
        in_valid = 1'b1;
        in_data = NC'(4);
        start = 1'b1;
        mode = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("ena_in_ready", in_ready, 0);
        check("ena_busy", busy, 1);
        check("ena_no_shift", en_cnt - e0, 3);
        start = 1'b0;
        in_valid = 1'b0;
        ena = 1'b1;
        do_start(1'b1);
        check("busy_start_ignored", {busy, out_valid, in_ready}, 3'b101);
        send_beats(3, CL - 1);
        finish_load(NC'(8), 1'b1, e0);

        // asynchronous reset mid-load
        do_start(1'b0);
        send_beats(0, 3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_outs", {in_ready, out_valid, out_data, chain_en, chain_din, busy, done, error, cfg_valid}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_load(NC'(8), 1'b1);

        // start then idle input for 20 cycles
        e0 = en_cnt;
        do_start(1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("idle_busy", busy, 1);
        check("idle_in_ready", in_ready, 1);
        check("idle_no_shift", en_cnt - e0, 0);
        send_beats(0, CL - 1);
        finish_load(NC'(8), 1'b1, e0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
